// File: rtl/sram_arbiter.sv
// Two-requester arbiter and wait-state sequencer for the shared 64-bit SRAM.
// Optional macro ROUND_ROBIN_EN: alternate grants under contention (default: MEM has fixed priority).
module sram_arbiter #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [63:0] mem_rline,
  output logic [31:0] mem_rdata,
  output logic [16:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  inout  wire  [63:0] SRAM_DQ,
  output logic [1:0]  dbg_state,
  output logic        dbg_last_owner
);

  // Handshake: a requester raises its request (with stable address/data) and
  // holds it until its ready pulses for one cycle; the request fields are
  // captured once in IDLE, so later input changes or a dropped request do not
  // affect the transaction already in flight.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0]  LAST_CNT  = 4'(WAIT_CYCLES - 1);
  localparam logic [19:0] BASE_LOW  = 20'(BASE_ADDR);
  localparam logic        OWNER_IF  = 1'b0;
  localparam logic        OWNER_MEM = 1'b1;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        owner_q;
  logic        write_q;
  logic        lane_q;
  logic        last_owner_q;
  logic [31:0] wdata_q;
  logic [16:0] sram_addr_q;

  logic        mem_pend;
  logic        any_pend;
  logic        grant_mem;
  logic [31:0] sel_addr;
  logic [19:0] rel_addr;
  logic        access_end;
  logic        drive_dq;
  logic        unused_addr_bits;

  assign mem_pend = mem_r_en | mem_w_en;
  assign any_pend = mem_pend | if_req;

`ifdef ROUND_ROBIN_EN
  assign grant_mem = mem_pend && (!if_req || (last_owner_q == OWNER_IF));
`else
  assign grant_mem = mem_pend;
`endif

  // Only the low 20 bits matter: the SRAM word index wraps modulo 2^17.
  assign sel_addr         = grant_mem ? mem_addr : if_addr;
  assign rel_addr         = sel_addr[19:0] - BASE_LOW;
  assign unused_addr_bits = ^{sel_addr[31:20], rel_addr[2:0]};

  assign access_end = (state_q == ACCESS) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pend) state_d = ACCESS;
      ACCESS:  if (access_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      owner_q      <= OWNER_IF;
      write_q      <= 1'b0;
      lane_q       <= 1'b0;
      last_owner_q <= OWNER_IF;
      wdata_q      <= '0;
      sram_addr_q  <= '0;
      if_ready     <= 1'b0;
      mem_ready    <= 1'b0;
      if_rdata     <= '0;
      mem_rdata    <= '0;
      mem_rline    <= '0;
    end else begin
      if_ready  <= access_end && (owner_q == OWNER_IF);
      mem_ready <= access_end && (owner_q == OWNER_MEM);

      if ((state_q == IDLE) && any_pend) begin
        owner_q      <= grant_mem;
        write_q      <= grant_mem && mem_w_en;
        lane_q       <= sel_addr[2];
        wdata_q      <= mem_wdata;
        sram_addr_q  <= rel_addr[19:3];
        last_owner_q <= grant_mem;
        cnt_q        <= '0;
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + 4'd1;
      end

      // Read data is sampled on the final wait-state cycle; the other side's data holds.
      if (access_end && !write_q) begin
        if (owner_q == OWNER_MEM) begin
          mem_rline <= SRAM_DQ;
          mem_rdata <= lane_q ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
        end else begin
          if_rdata <= lane_q ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
        end
      end
    end
  end

  assign drive_dq  = (state_q == ACCESS) && write_q;
  assign SRAM_WE_N = !drive_dq;
  assign SRAM_ADDR = sram_addr_q;

  assign SRAM_DQ[31:0]  = (drive_dq && !lane_q) ? wdata_q : 32'hz;
  assign SRAM_DQ[63:32] = (drive_dq &&  lane_q) ? wdata_q : 32'hz;

  assign dbg_state      = state_q;
  assign dbg_last_owner = last_owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed transactions push expected
// responses; a negedge monitor pops and compares on every ready pulse.
module tb_sram_arbiter;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req, mem_r_en, mem_w_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_ready, mem_ready, SRAM_WE_N, dbg_last_owner;
  logic [31:0] if_rdata, mem_rdata;
  logic [63:0] mem_rline;
  logic [16:0] SRAM_ADDR;
  logic [1:0]  dbg_state;
  tri1  [63:0] SRAM_DQ;

  sram_arbiter #(.WAIT_CYCLES(W), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rline(mem_rline), .mem_rdata(mem_rdata),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ(SRAM_DQ),
    .dbg_state(dbg_state), .dbg_last_owner(dbg_last_owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: drives read data while the write enable is inactive
  logic [63:0] sram_mem [16];
  logic        model_en = 1'b0;
  logic [63:0] rd_word;
  assign rd_word = sram_mem[SRAM_ADDR[3:0]];
  assign SRAM_DQ = (model_en && SRAM_WE_N) ? rd_word : 64'hz;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // entry = {is_mem, ready_cycle[15:0], rline[63:0], rdata[31:0]}
  logic [112:0] exp_q[$];
  logic         exp_last_mem = 1'b0;
  logic [31:0]  exp_mem_rdata_h = '0;
  logic [63:0]  exp_mem_rline_h = '0;

  task automatic push_exp(input logic is_mem, input logic is_write, input logic [31:0] addr,
                          input int ready_cyc);
    logic [19:0] rel;
    logic [63:0] word;
    logic [31:0] lane;
    rel  = addr[19:0] - 20'd1024;
    word = sram_mem[rel[6:3]];
    lane = addr[2] ? word[63:32] : word[31:0];
    if (is_mem && !is_write) begin
      exp_mem_rline_h = word;
      exp_mem_rdata_h = lane;
    end
    if (is_mem) exp_q.push_back({1'b1, 16'(ready_cyc), exp_mem_rline_h, exp_mem_rdata_h});
    else        exp_q.push_back({1'b0, 16'(ready_cyc), 64'h0, lane});
    exp_last_mem = is_mem;
  endtask

  // Monitor
  logic [31:0] mon_if_h = '0;
  logic [31:0] mon_mem_rdata_h = '0;
  logic [63:0] mon_mem_rline_h = '0;

  always @(negedge clk) begin
    logic [112:0] e;
    if (rst) begin
      mon_if_h = '0;
      mon_mem_rdata_h = '0;
      mon_mem_rline_h = '0;
    end else if (if_ready || mem_ready) begin
      if (if_ready && mem_ready) check("both_ready", 64'd1, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {62'd0, mem_ready, if_ready}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ready_owner_is_mem", {63'd0, mem_ready}, {63'd0, e[112]});
        check("ready_cycle", 64'(cyc), {48'd0, e[111:96]});
        if (mem_ready) begin
          check("mem_rline", mem_rline, e[95:32]);
          check("mem_rdata", {32'd0, mem_rdata}, {32'd0, e[31:0]});
          check("if_rdata_hold", {32'd0, if_rdata}, {32'd0, mon_if_h});
          mon_mem_rline_h = e[95:32];
          mon_mem_rdata_h = e[31:0];
        end else begin
          check("if_rdata", {32'd0, if_rdata}, {32'd0, e[31:0]});
          check("mem_rdata_hold", {32'd0, mem_rdata}, {32'd0, mon_mem_rdata_h});
          check("mem_rline_hold", mem_rline, mon_mem_rline_h);
          mon_if_h = e[31:0];
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if_ready || mem_ready) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout actual=no_ready expected=ready within 40 cycles", name);
  endtask

  task automatic run_read(input logic is_mem, input logic [31:0] addr, input logic [16:0] exp_saddr);
    if (is_mem) begin mem_r_en = 1'b1; mem_addr = addr; end
    else        begin if_req = 1'b1;   if_addr = addr;  end
    push_exp(is_mem, 1'b0, addr, cyc + 1 + W);
    @(posedge clk); @(negedge clk);
    check("read_sram_addr", {47'd0, SRAM_ADDR}, {47'd0, exp_saddr});
    check("read_we_n", {63'd0, SRAM_WE_N}, 64'd1);
    wait_ready("read");
    @(posedge clk); #1;
    if_req = 1'b0;
    mem_r_en = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [16:0] exp_saddr, input logic both);
    mem_w_en = 1'b1; mem_r_en = both; mem_addr = addr; mem_wdata = wdata;
    push_exp(1'b1, 1'b1, addr, cyc + 1 + W);
    for (int k = 0; k < W; k++) begin
      @(posedge clk); @(negedge clk);
      check("write_we_n_low", {63'd0, SRAM_WE_N}, 64'd0);
      check("write_sram_addr", {47'd0, SRAM_ADDR}, {47'd0, exp_saddr});
      if (addr[2]) begin
        check("write_dq_hi", {32'd0, SRAM_DQ[63:32]}, {32'd0, wdata});
        check("write_dq_lo_z", {32'd0, SRAM_DQ[31:0]}, 64'hFFFF_FFFF);
      end else begin
        check("write_dq_lo", {32'd0, SRAM_DQ[31:0]}, {32'd0, wdata});
        check("write_dq_hi_z", {32'd0, SRAM_DQ[63:32]}, 64'hFFFF_FFFF);
      end
    end
    @(posedge clk); @(negedge clk);
    check("write_done_we_n", {63'd0, SRAM_WE_N}, 64'd1);
    @(posedge clk); #1;
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_if_ready"}, {63'd0, if_ready}, 64'd0);
    check({tag, "_mem_ready"}, {63'd0, mem_ready}, 64'd0);
    check({tag, "_we_n"}, {63'd0, SRAM_WE_N}, 64'd1);
    check({tag, "_sram_addr"}, {47'd0, SRAM_ADDR}, 64'd0);
    check({tag, "_if_rdata"}, {32'd0, if_rdata}, 64'd0);
    check({tag, "_mem_rdata"}, {32'd0, mem_rdata}, 64'd0);
    check({tag, "_mem_rline"}, mem_rline, 64'd0);
    check({tag, "_dq_z"}, SRAM_DQ, 64'hFFFF_FFFF_FFFF_FFFF);
    check({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
    check({tag, "_last_owner"}, {63'd0, dbg_last_owner}, 64'd0);
  endtask

  initial begin
    logic gm;
    int   c;
    if_req = 0; mem_r_en = 0; mem_w_en = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < 16; i++) sram_mem[i] = 64'(i) * 64'h0101_0101_0101_0101;
    sram_mem[0]  = 64'hAAAA_BBBB_1111_2222;
    sram_mem[2]  = 64'h0123_4567_89AB_CDEF;
    sram_mem[3]  = 64'h7777_8888_9999_AAAA;
    sram_mem[15] = 64'hCAFE_F00D_5555_6666;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_en = 1'b1;

    run_read(1'b0, 32'd1028, 17'd0);                    // single fetch
    run_write(32'd1032, 32'hDEAD_BEEF, 17'd1, 1'b0);    // MEM store, low lane
    run_read(1'b1, 32'd1040, 17'd2);                    // MEM fill
    run_write(32'd1036, 32'h5A5A_C3C3, 17'd1, 1'b1);    // r_en+w_en acts as write, high lane
    run_read(1'b0, 32'd1020, 17'h1FFFF);                // below base wraps

    // Contention: both held for four grants
    c = cyc;
    if_req = 1'b1; if_addr = 32'd1028; mem_r_en = 1'b1; mem_addr = 32'd1040;
    for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
      gm = !exp_last_mem;
`else
      gm = 1'b1;
`endif
      push_exp(gm, 1'b0, gm ? 32'd1040 : 32'd1028, c + 1 + W + k * (W + 2));
    end
    for (int k = 0; k < 4; k++) wait_ready("contention");
    @(posedge clk); #1;
    if_req = 1'b0; mem_r_en = 1'b0;

    // Dropped request mid-access
    mem_r_en = 1'b1; mem_addr = 32'd1048;
    push_exp(1'b1, 1'b0, 32'd1048, cyc + 1 + W);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    wait_ready("dropped");
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dropped_stays_idle", {62'd0, dbg_state}, 64'd0);
      @(posedge clk);
    end
    #1;

    // Reset during the 3rd ACCESS cycle of a write
    model_en = 1'b0;
    mem_w_en = 1'b1; mem_addr = 32'd1032; mem_wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mem_w_en = 1'b0;
    @(negedge clk);
    check("pre_reset_we_n_low", {63'd0, SRAM_WE_N}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_last_mem = 1'b0;
    exp_mem_rdata_h = '0;
    exp_mem_rline_h = '0;
    @(negedge clk);
    check_reset_values("midrst");
    repeat (8) @(posedge clk);
    #1;
    model_en = 1'b1;
    run_read(1'b0, 32'd1028, 17'd0);                    // recovery after abandoned write

    repeat (5) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
